// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared state encodings and sweep mode constants
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

endpackage

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - combinational binary to Gray converter
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_sweep_ctrl.sv
// rtl/gray_sweep_ctrl.sv - bounded up/down/ping-pong code sweep with Gray output
module gray_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             step_en,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import gray_pkg::*;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_q, lo_q, hi_q;
  logic [1:0]       mode_q;
  logic             dir_down;
  logic             err_q;
  logic             accept;
  logic             last_code;

  assign accept = start && (lo <= hi);

  // The final code is recognised before stepping, so the counter never wraps.
  always_comb begin
    last_code = 1'b0;
    case (mode_q)
      MODE_DOWN: last_code = (bin_q == lo_q);
      MODE_PP:   last_code = dir_down ? (bin_q == lo_q)
                                      : ((bin_q == hi_q) && (bin_q == lo_q));
      default:   last_code = (bin_q == hi_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (step_en && last_code) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    valid = (state == ST_RUN);
    busy  = (state == ST_RUN) || (state == ST_DONE);
    done  = (state == ST_DONE);
    err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      mode_q   <= MODE_UP;
      dir_down <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !accept) begin
            err_q <= 1'b1;
          end else if (accept) begin
            lo_q     <= lo;
            hi_q     <= hi;
            // Reserved mode collapses to up here so the run logic sees three modes.
            mode_q   <= ((mode == MODE_DOWN) || (mode == MODE_PP)) ? mode : MODE_UP;
            bin_q    <= (mode == MODE_DOWN) ? hi : lo;
            dir_down <= 1'b0;
          end
        end
        ST_RUN: begin
          if (step_en && !last_code) begin
            case (mode_q)
              MODE_DOWN: bin_q <= bin_q - WIDTH'(1);
              MODE_PP: begin
                if (dir_down) begin
                  bin_q <= bin_q - WIDTH'(1);
                end else if (bin_q == hi_q) begin
                  dir_down <= 1'b1;
                  bin_q    <= bin_q - WIDTH'(1);
                end else begin
                  bin_q <= bin_q + WIDTH'(1);
                end
              end
              default: bin_q <= bin_q + WIDTH'(1);
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bin = bin_q;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (bin_q),
    .gray (gray)
  );

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// tb/tb_gray_sweep_ctrl.sv - directed self-checking bench for gray_sweep_ctrl
module tb_gray_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] lo, hi;
  logic       step_en;
  logic [3:0] bin, gray;
  logic       valid, busy, done, err;

  int passed = 0;
  int total  = 0;

  gray_sweep_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .step_en (step_en),
    .bin     (bin),
    .gray    (gray),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_run(input string tag, input logic [3:0] eb, input logic [3:0] eg);
    check({tag, "_bin"}, {28'd0, bin}, {28'd0, eb});
    check({tag, "_gray"}, {28'd0, gray}, {28'd0, eg});
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_done(input string tag, input logic [3:0] eb);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_hold"}, {28'd0, bin}, {28'd0, eb});
  endtask

  task automatic launch(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h);
    mode = m; lo = l; hi = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [3:0] up_g [4];
  logic [3:0] dn_g [3];
  logic [3:0] pp_b [5];
  logic [3:0] pp_g [5];

  initial begin
    up_g = '{4'b0011, 4'b0010, 4'b0110, 4'b0111};
    dn_g = '{4'b1000, 4'b1001, 4'b1011};
    pp_b = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0};
    pp_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b0000};

    rst = 1'b1; start = 1'b0; mode = 2'b00; lo = '0; hi = '0; step_en = 1'b0;
    tick(); tick();
    check("rst_bin", {28'd0, bin}, 32'd0);
    check("rst_gray", {28'd0, gray}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();

    // Up 2..5; inputs disturbed after acceptance and a start pulse mid-run.
    step_en = 1'b1;
    launch(2'b00, 4'd2, 4'd5);
    mode = 2'b01; lo = 4'd0; hi = 4'd15;
    for (int i = 0; i < 4; i++) begin
      check_run($sformatf("up_%0d", i), 4'd2 + 4'(i), up_g[i]);
      check($sformatf("up_busy_%0d", i), {31'd0, busy}, 32'd1);
      start = (i == 1);
      tick();
    end
    start = 1'b0;
    check_done("up_end", 4'd5);
    check("up_end_err", {31'd0, err}, 32'd0);
    tick();
    check("up_idle_done", {31'd0, done}, 32'd0);
    check("up_idle_busy", {31'd0, busy}, 32'd0);
    check("up_idle_gray", {28'd0, gray}, 32'h7);

    // Down 13..15
    launch(2'b01, 4'd13, 4'd15);
    for (int i = 0; i < 3; i++) begin
      check_run($sformatf("dn_%0d", i), 4'd15 - 4'(i), dn_g[i]);
      tick();
    end
    check_done("dn_end", 4'd13);
    tick();

    // Ping-pong 0..2
    launch(2'b10, 4'd0, 4'd2);
    for (int i = 0; i < 5; i++) begin
      check_run($sformatf("pp_%0d", i), pp_b[i], pp_g[i]);
      tick();
    end
    check_done("pp_end", 4'd0);
    tick();

    // Rejected start: lo > hi
    launch(2'b00, 4'd6, 4'd3);
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_valid", {31'd0, valid}, 32'd0);
    tick();
    check("err_clear", {31'd0, err}, 32'd0);
    check("err_bin_held", {28'd0, bin}, 32'd0);
    check("err_still_idle", {31'd0, busy}, 32'd0);

    // Full range up with a stall cycle before each accepted step
    launch(2'b00, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      step_en = 1'b0;
      check_run($sformatf("stall_a_%0d", i), 4'(i), 4'(i) ^ (4'(i) >> 1));
      tick();
      step_en = 1'b1;
      check_run($sformatf("stall_b_%0d", i), 4'(i), 4'(i) ^ (4'(i) >> 1));
      tick();
    end
    check_done("full_end", 4'd15);
    tick();
    check("full_done_once", {31'd0, done}, 32'd0);
    check("full_no_wrap", {28'd0, bin}, 32'd15);

    // Ping-pong with a single-code range
    launch(2'b10, 4'd7, 4'd7);
    check_run("pp1", 4'd7, 4'b0100);
    tick();
    check_done("pp1_end", 4'd7);
    tick();

    // Reserved mode behaves as up
    launch(2'b11, 4'd14, 4'd15);
    check_run("rsv_0", 4'd14, 4'b1001);
    tick();
    check_run("rsv_1", 4'd15, 4'b1000);
    tick();
    check_done("rsv_end", 4'd15);
    tick();

    // Reset in the middle of a sweep at bin=4
    launch(2'b00, 4'd0, 4'd10);
    repeat (4) tick();
    check("mid_bin4", {28'd0, bin}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_bin", {28'd0, bin}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    tick();
    check("mid_no_done", {31'd0, done}, 32'd0);
    launch(2'b00, 4'd1, 4'd1);
    check_run("post_rst", 4'd1, 4'b0001);
    tick();
    check_done("post_rst_end", 4'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gray_sweep_ctrl.md
GRAY_SWEEP_CTRL -- requirements
Module: gray_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, code width in bits of range bounds and outputs.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a sweep; sampled only in IDLE.
REQ-005 mode  input  2  sweep mode: 00 up, 01 down, 10 ping-pong, 11 reserved (treated as up).
REQ-006 lo  input  WIDTH  lower range bound, inclusive; sampled with start.
REQ-007 hi  input  WIDTH  upper range bound, inclusive; sampled with start.
REQ-008 step_en  input  1  consumer accepts the current code this cycle.
REQ-009 bin  output  WIDTH  current binary code, registered.
REQ-010 gray  output  WIDTH  Gray encoding of bin: gray = bin XOR (bin >> 1), same cycle as bin.
REQ-011 valid  output  1  bin/gray carry a sweep code.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  single-cycle pulse on sweep completion.
REQ-014 err  output  1  single-cycle pulse when start is rejected.

Function
REQ-015 States: IDLE, RUN, DONE; state register one-hot or binary, implementer's choice.
REQ-016 IDLE: start=1 and lo<=hi -> latch lo, hi, mode; load bin with lo (up, ping-pong) or hi (down); next state RUN.
REQ-017 IDLE: start=1 and lo>hi -> err=1 on the next cycle; remain in IDLE; bin unchanged.
REQ-018 RUN: valid=1; code held unchanged while step_en=0 (no timeout).
REQ-019 Up: step_en=1 and bin!=hi -> bin+1; step_en=1 and bin==hi -> next state DONE.
REQ-020 Down: step_en=1 and bin!=lo -> bin-1; step_en=1 and bin==lo -> next state DONE.
REQ-021 Ping-pong: internal direction flag starts up; at bin==hi with step_en flag flips to down and bin-1; at bin==lo with flag down and step_en -> DONE.
REQ-022 Ping-pong with lo==hi: single code presented, one step_en -> DONE.
REQ-023 Arithmetic WIDTH bits; range checks prevent wrap-around, so hi=2^WIDTH-1 or lo=0 never wraps.
REQ-024 DONE: lasts exactly one cycle; done=1, valid=0, busy=1; next state IDLE.
REQ-025 bin/gray hold last presented code in DONE and IDLE until next accepted start.
REQ-026 start in RUN or DONE ignored; no err.
REQ-027 lo, hi, mode changes after acceptance have no effect on the running sweep.
REQ-028 First code appears cycle after start acceptance; sweep of N codes with step_en held 1 completes with done N+1 cycles after start.

Reset
REQ-029 rst=1 at any edge: state IDLE, bin=0, gray=0, valid=0, busy=0, done=0, err=0, direction flag up.
REQ-030 rst has priority over start and step_en; mid-sweep reset abandons sweep with no done pulse.

Structure
REQ-031 Shared package gray_pkg holds state encodings and mode constants (MODE_UP, MODE_DOWN, MODE_PP).
REQ-032 One sub-module bin2gray (parameter WIDTH, combinational) produces gray from bin; instantiated once.

Verification
REQ-033 Up lo=2 hi=5, step_en=1: gray 0011,0010,0110,0111 on cycles 1-4; done=1 cycle 5; valid=0 cycle 5.
REQ-034 Down lo=13 hi=15: gray 1000,1001,1011 then done; no wrap past 13.
REQ-035 Ping-pong lo=0 hi=2: bin 0,1,2,1,0, gray 0000,0001,0011,0001,0000, then done.
REQ-036 lo=6 hi=3 start: err pulse one cycle, busy stays 0, no valid.
REQ-037 Up lo=0 hi=15 with step_en toggling 1/0: each code held through stall cycles; 16 codes; done once; no wrap to 0.
REQ-038 rst asserted mid-sweep at bin=4: next cycle all outputs 0, IDLE; subsequent start accepted normally.
